// File: rtl/rv4028_bus_target_if.sv
// rv4028_bus_target_if: RV4028 external bus pins seen between CPU (master) and memory target (slave)
interface rv4028_bus_target_if;
  logic [31:0] addr;
  logic        rd_n;
  logic [1:0]  wr_n;
  logic [1:0]  msk_n;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_oe;
  logic        wait_n;
  modport master(output addr, rd_n, wr_n, msk_n, data_in, input data_out, data_oe, wait_n);
  modport slave(input addr, rd_n, wr_n, msk_n, data_in, output data_out, data_oe, wait_n);
endinterface

// File: rtl/rv4028_bus_target.sv
// rv4028_bus_target: windowed RV4028 bus responder with stretched reads and a 2-entry posted write FIFO
module rv4028_bus_target #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_W      = 11,
  parameter int          WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rv4028_bus_target_if.slave    bus,
  output logic                  wr_overflow,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [15:0]           mem_wdata,
  output logic [1:0]            mem_be,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [15:0]           mem_rdata
);
  localparam int EW = ADDR_W + 18;
  localparam int CW = WAIT_STATES > 0 ? $clog2(WAIT_STATES + 1) : 1;
  typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_DATA, WR_DATA} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [15:0]       hold_q, hold_d;
  logic              hold_v_q, hold_v_d, ovf_q, ovf_d;
  logic [1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [EW-1:0]     fifo_q [2];
  logic [EW-1:0]     fifo_d [2];
  logic [EW-1:0]     head;
  logic              sel, empty, full, start_rd, start_wr, rd_issue, pop, push, push_ok, dv, rd_ready;
  logic              unused_ok;
  assign unused_ok   = bus.addr[0];
  assign sel         = bus.addr[31:ADDR_W+1] == BASE_ADDR[31:ADDR_W+1];
  assign empty       = wptr_q == rptr_q;
  assign full        = wptr_q == {~rptr_q[1], rptr_q[0]};
  assign start_wr    = state_q == IDLE && sel && bus.wr_n != 2'b11;
  assign start_rd    = state_q == IDLE && sel && !bus.rd_n && bus.wr_n == 2'b11;
  assign rd_issue    = empty && (start_rd || state_q == RD_ISSUE);
  assign head        = fifo_q[rptr_q[0]];
  assign pop         = !empty && mem_gnt;
  assign push        = state_q == WR_DATA;
  assign push_ok     = push && (!full || pop);
  assign dv          = hold_v_q || mem_rvalid;
  assign rd_ready    = state_q == RD_DATA && dv && wcnt_q == '0;
  assign mem_req     = rd_issue || !empty;
  assign mem_we      = !rd_issue && !empty;
  assign mem_addr    = rd_issue ? (state_q == IDLE ? bus.addr[ADDR_W:1] : addr_q) : head[EW-1 -: ADDR_W];
  assign mem_wdata   = head[17:2];
  assign mem_be      = rd_issue ? 2'b11 : head[1:0];
  assign wr_overflow = ovf_q;
  assign bus.data_oe  = state_q == RD_ISSUE || state_q == RD_DATA;
  assign bus.data_out = state_q == RD_DATA ? (mem_rvalid ? mem_rdata : hold_q) : 16'h0;
  assign bus.wait_n   = !(state_q == RD_ISSUE || (state_q == RD_DATA && !rd_ready));
  always_comb begin
    state_d  = start_wr ? WR_DATA :
               (start_rd || state_q == RD_ISSUE) ? ((rd_issue && mem_gnt) ? RD_DATA : RD_ISSUE) :
               state_q == RD_DATA ? (rd_ready ? IDLE : RD_DATA) : IDLE;
    addr_d   = (start_rd || start_wr) ? bus.addr[ADDR_W:1] : addr_q;
    wcnt_d   = start_rd ? CW'(WAIT_STATES) :
               (state_q == RD_DATA && wcnt_q != '0) ? wcnt_q - CW'(1) : wcnt_q;
    hold_d   = (state_q == RD_DATA && mem_rvalid) ? mem_rdata : hold_q;
    hold_v_d = state_q == RD_DATA && dv;
    wptr_d   = wptr_q + {1'b0, push_ok};
    rptr_d   = rptr_q + {1'b0, pop};
    ovf_d    = ovf_q || (push && !push_ok);
    fifo_d   = fifo_q;
    if (push_ok) fifo_d[wptr_q[0]] = {addr_q, bus.data_in, ~bus.msk_n};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      ovf_q    <= 1'b0;
      wcnt_q   <= '0;
      hold_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      ovf_q    <= ovf_d;
      wcnt_q   <= wcnt_d;
      hold_v_q <= hold_v_d;
    end
    addr_q <= addr_d;
    hold_q <= hold_d;
    fifo_q <= fifo_d;
  end
endmodule
